// File: rtl/hier_leaf_stream_fifo.sv
// Leaf stream buffer: first-word-fall-through valid/ready FIFO with packet
// framing, drained-packet counter and sticky framing-error flag.
module hier_leaf_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           pkt_count,
  output logic                       pkt_done,
  output logic                       frame_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {IDLE, IN_PKT} state_t;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             last_mem;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [LW-1:0]                level_q;
  logic                         rst_d;
  state_t                       state_q, state_d;
  logic                         push, pop;

  // Handshake flags depend only on registered occupancy.
  assign in_ready  = (level_q != FULL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];
  assign out_last  = last_mem[rd_ptr];
  assign level     = level_q;

  always_comb begin
    state_d = state_q;
    if (push) state_d = in_last ? IDLE : IN_PKT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem       <= '0;
      last_mem  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      state_q   <= IDLE;
      pkt_count <= '0;
      pkt_done  <= 1'b0;
      frame_err <= 1'b0;
      rst_d     <= 1'b1;
    end else begin
      rst_d    <= 1'b0;
      state_q  <= state_d;
      pkt_done <= pop && out_last;
      if (push) begin
        mem[wr_ptr]      <= in_data;
        last_mem[wr_ptr] <= in_last;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (pop && out_last) pkt_count <= pkt_count + CNT_W'(1);
      // Last beat right out of reset, or a zero-payload single-beat packet,
      // marks an empty packet.
      if (push && in_last && (rst_d || (state_q == IDLE && in_data == '0)))
        frame_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hier_leaf_stream_fifo.sv
// Directed self-checking bench for hier_leaf_stream_fifo (CNT_W=4 to reach wrap).
module tb_hier_leaf_stream_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_data;
  logic [2:0] level;
  logic [3:0] pkt_count;
  logic       pkt_done, frame_err;

  int nchk = 0;
  int nerr = 0;
  int exp_cnt;

  hier_leaf_stream_fifo #(.DATA_W(8), .DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .level(level), .pkt_count(pkt_count), .pkt_done(pkt_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    in_valid = v; in_data = d; in_last = l;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    drive(1'b0, 8'h00, 1'b0);

    // 1: reset
    step(); step();
    rst = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_out_data", out_data, 0);
    step();

    // 2: single-beat packet
    out_ready = 1'b1;
    drive(1'b1, 8'hA5, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk("sb_out_valid", out_valid, 1);
    chk("sb_out_data", out_data, 8'hA5);
    chk("sb_out_last", out_last, 1);
    chk("sb_pkt_done_early", pkt_done, 0);
    step();
    chk("sb_pkt_done", pkt_done, 1);
    chk("sb_pkt_count", pkt_count, 1);
    chk("sb_level", level, 0);
    step();
    chk("sb_pkt_done_clr", pkt_done, 0);
    chk("sb_frame_err", frame_err, 0);

    // 3: fill to full, fifth beat held off
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      step();
    end
    chk("full_level", level, 4);
    chk("full_in_ready", in_ready, 0);
    drive(1'b1, 8'h05, 1'b1);
    step();
    chk("full_hold_level", level, 4);
    chk("full_head", out_data, 8'h01);
    out_ready = 1'b1;
    step();
    chk("drain1_data", out_data, 8'h02);
    chk("drain1_level", level, 3);
    chk("drain1_in_ready", in_ready, 1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk("drain2_data", out_data, 8'h03);
    chk("drain2_level", level, 3);
    step();
    chk("drain3_data", out_data, 8'h04);
    step();
    chk("drain4_data", out_data, 8'h05);
    chk("drain4_last", out_last, 1);
    chk("drain4_level", level, 1);
    step();
    chk("drain5_level", level, 0);
    chk("drain5_pkt_done", pkt_done, 1);
    chk("drain5_pkt_count", pkt_count, 2);

    // 4: steady push/pop at level 2
    out_ready = 1'b0;
    drive(1'b1, 8'h20, 1'b0); step();
    drive(1'b1, 8'h21, 1'b0); step();
    chk("pp_pre_level", level, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'h22 + i), 1'b0);
      step();
      chk("pp_level", level, 2);
      chk("pp_data", out_data, 8'(8'h21 + i));
    end
    drive(1'b0, 8'h00, 1'b0);
    step(); step();
    chk("pp_drain_level", level, 0);

    // 5: counter wrap with back-to-back single-beat packets
    exp_cnt = 2;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b1);
      step();
      if (i > 0) begin
        exp_cnt = (exp_cnt + 1) % 16;
        chk("wrap_cnt", pkt_count, exp_cnt);
        chk("wrap_done", pkt_done, 1);
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    step();
    exp_cnt = (exp_cnt + 1) % 16;
    chk("wrap_cnt_final", pkt_count, 3);
    chk("wrap_cnt_model", pkt_count, exp_cnt);
    step();
    chk("wrap_done_clr", pkt_done, 0);

    // 6: reset mid-packet
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0);
      step();
    end
    chk("mid_level", level, 3);
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_pkt_count", pkt_count, 0);
    step();
    out_ready = 1'b1;
    drive(1'b1, 8'h10, 1'b0); step();
    chk("mid_new_head", out_data, 8'h10);
    drive(1'b1, 8'h11, 1'b1); step();
    chk("mid_new_head2", out_data, 8'h11);
    drive(1'b0, 8'h00, 1'b0); step();
    chk("mid_new_pkt_count", pkt_count, 1);
    chk("mid_new_pkt_done", pkt_done, 1);
    chk("mid_new_frame_err", frame_err, 0);

    // 7: framing errors
    drive(1'b1, 8'h55, 1'b0); step();
    drive(1'b1, 8'h00, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0); step();
    chk("fe_zero_in_pkt", frame_err, 0);
    drive(1'b1, 8'h00, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0);
    chk("fe_zero_idle", frame_err, 1);
    chk("fe_beat_stored", out_valid, 1);
    step(); step();
    chk("fe_sticky", frame_err, 1);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("fe_rst_clear", frame_err, 0);
    drive(1'b1, 8'h77, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0);
    chk("fe_rst_race", frame_err, 1);
    chk("fe_rst_race_level", level, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
